// File: rtl/riscv_pkg.sv
// Shared constants for the single-cycle RV32I subset core: opcodes,
// ALU operation codes and the main-control to ALU-control encoding.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  // Main control tells ALU control to add, subtract, or look at funct fields.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

endpackage

// File: rtl/riscv_alu.sv
// 32-bit ALU: and, or, add, sub with wrap-around; zero flag for beq.
module alu
  import riscv_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  alu_control,
  output logic [31:0] result,
  output logic        zero
);

  // Compute the selected operation.
  always_comb begin
    result = a + b;
    case (alu_control)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      default: result = a + b;
    endcase
  end

  assign zero = (result == 32'd0);

endmodule

// File: rtl/riscv_alu_ctrl.sv
// Maps main-control ALUOp plus funct3/funct7[5] onto a 4-bit ALU code.
// Unrecognised R-type functs fall back to add.
module alu_ctrl
  import riscv_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] alu_control
);

  // Select the ALU operation.
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          F3_ADD:  alu_control = funct7_5 ? ALU_SUB : ALU_ADD;
          F3_AND:  alu_control = ALU_AND;
          F3_OR:   alu_control = ALU_OR;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/riscv_instr_mem.sv
// Instruction memory: 256 words indexed directly by the low PC byte.
// Contents are loaded from outside; reset does not touch them.
module instr_mem
  import riscv_pkg::*;
(
  input  logic [7:0]  addr,
  output logic [31:0] instr
);

  logic [31:0] I_mem [0:255];

  // Combinational fetch.
  assign instr = I_mem[addr];

endmodule

// File: rtl/riscv_regfile.sv
// 32 x 32-bit register file, two combinational read ports, one write port.
// x0 reads as zero and ignores writes; reset clears every register.
module regfile
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data1,
  output logic [31:0] rd_data2
);

  logic [31:0] regs [0:31];

  // Synchronous clear on reset, otherwise write rd unless it is x0.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && (rd_addr != 5'd0)) begin
      regs[rd_addr] <= wr_data;
    end
  end

  assign rd_data1 = (rs1_addr == 5'd0) ? 32'd0 : regs[rs1_addr];
  assign rd_data2 = (rs2_addr == 5'd0) ? 32'd0 : regs[rs2_addr];

endmodule

// File: rtl/riscv_top.sv
// Single-cycle RV32I subset core (add/sub/and/or, addi, lw, sw, beq).
// PC, register file and data memory all update on the same rising edge;
// everything between them is combinational from the current PC.
module riscv_top
  import riscv_pkg::*;
(
  input  logic clk,
  input  logic reset
);

  logic [31:0] PC_current;
  logic [31:0] pc_next;
  logic [31:0] instruction;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic [31:0] alu_input2;
  logic [31:0] alu_result;
  logic [31:0] imm;
  logic [31:0] dmem_read;
  logic [31:0] write_data;
  logic        RegWrite;
  logic        ALUSrc;
  logic        MemToReg;
  logic        MemWrite;
  logic        Branch;
  logic        zero;
  logic [1:0]  ALUOp;
  logic [3:0]  ALU_control;
  logic [6:0]  opcode;
  logic [2:0]  funct3;

  logic [31:0] dmem [0:63];

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];

  instr_mem INSTR_MEM (
    .addr  (PC_current[7:0]),
    .instr (instruction)
  );

  // Main control decode; unknown opcodes (and addi with other funct3) are NOPs.
  always_comb begin
    RegWrite = 1'b0;
    ALUSrc   = 1'b0;
    MemToReg = 1'b0;
    MemWrite = 1'b0;
    Branch   = 1'b0;
    ALUOp    = ALUOP_ADD;
    case (opcode)
      OP_R: begin
        RegWrite = 1'b1;
        ALUOp    = ALUOP_FUNCT;
      end
      OP_I: begin
        if (funct3 == F3_ADD) begin
          RegWrite = 1'b1;
          ALUSrc   = 1'b1;
        end
      end
      OP_LOAD: begin
        RegWrite = 1'b1;
        ALUSrc   = 1'b1;
        MemToReg = 1'b1;
      end
      OP_STORE: begin
        MemWrite = 1'b1;
        ALUSrc   = 1'b1;
      end
      OP_BRANCH: begin
        Branch = 1'b1;
        ALUOp  = ALUOP_SUB;
      end
      default: ;
    endcase
  end

  // Sign-extended immediate in the format implied by the opcode.
  always_comb begin
    imm = {{20{instruction[31]}}, instruction[31:20]};
    case (opcode)
      OP_STORE:  imm = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      OP_BRANCH: imm = {{19{instruction[31]}}, instruction[31], instruction[7],
                        instruction[30:25], instruction[11:8], 1'b0};
      default:   imm = {{20{instruction[31]}}, instruction[31:20]};
    endcase
  end

  regfile register_file (
    .clk      (clk),
    .reset    (reset),
    .we       (RegWrite),
    .rs1_addr (instruction[19:15]),
    .rs2_addr (instruction[24:20]),
    .rd_addr  (instruction[11:7]),
    .wr_data  (write_data),
    .rd_data1 (read_data1),
    .rd_data2 (read_data2)
  );

  alu_ctrl u_alu_ctrl (
    .alu_op      (ALUOp),
    .funct3      (funct3),
    .funct7_5    (instruction[30]),
    .alu_control (ALU_control)
  );

  assign alu_input2 = ALUSrc ? imm : read_data2;

  alu u_alu (
    .a           (read_data1),
    .b           (alu_input2),
    .alu_control (ALU_control),
    .result      (alu_result),
    .zero        (zero)
  );

  assign dmem_read  = dmem[alu_result[7:2]];
  assign write_data = MemToReg ? dmem_read : alu_result;

  // Data memory: cleared on reset, word write on sw.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) dmem[i] <= '0;
    end else if (MemWrite) begin
      dmem[alu_result[7:2]] <= read_data2;
    end
  end

  assign pc_next = (Branch && zero) ? (PC_current + imm) : (PC_current + 32'd4);

  // Program counter.
  always_ff @(posedge clk) begin
    if (reset) PC_current <= '0;
    else       PC_current <= pc_next;
  end

endmodule

// File: tb/tb_riscv_top.sv
// Bench for riscv_top: directed program from the test plan, then random
// programs checked against an instruction-level model of the ISA subset.
module tb_riscv_top;

  logic clk = 1'b0;
  logic reset = 1'b1;

  riscv_top dut (
    .clk   (clk),
    .reset (reset)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  logic [31:0] prog   [256];
  logic [31:0] m_regs [32];
  logic [31:0] m_dmem [64];
  logic [31:0] m_pc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 256; i++) dut.INSTR_MEM.I_mem[i] = prog[i];
  endtask

  // Architectural model: executes one instruction (or a reset) on the model state.
  task automatic model_step(input logic rst);
    logic [31:0] ins, a, b, immi, imms, immb, res, addr, nxt;
    logic [4:0]  rd;
    logic        wr;
    if (rst) begin
      m_pc = 32'd0;
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      for (int i = 0; i < 64; i++) m_dmem[i] = 32'd0;
      return;
    end
    ins  = prog[m_pc % 256];
    a    = (ins[19:15] == 5'd0) ? 32'd0 : m_regs[ins[19:15]];
    b    = (ins[24:20] == 5'd0) ? 32'd0 : m_regs[ins[24:20]];
    immi = {{20{ins[31]}}, ins[31:20]};
    imms = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    immb = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    rd   = ins[11:7];
    nxt  = m_pc + 32'd4;
    wr   = 1'b0;
    res  = 32'd0;
    case (ins[6:0])
      7'h33: begin
        wr = 1'b1;
        case (ins[14:12])
          3'd0:    res = ins[30] ? a - b : a + b;
          3'd7:    res = a & b;
          3'd6:    res = a | b;
          default: res = a + b;
        endcase
      end
      7'h13: if (ins[14:12] == 3'd0) begin wr = 1'b1; res = a + immi; end
      7'h03: begin
        addr = a + immi;
        wr   = 1'b1;
        res  = m_dmem[(addr / 4) % 64];
      end
      7'h23: begin
        addr = a + imms;
        m_dmem[(addr / 4) % 64] = b;
      end
      7'h63: if (a == b) nxt = m_pc + immb;
      default: ;
    endcase
    if (wr && rd != 5'd0) m_regs[rd] = res;
    m_pc = nxt;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [11:0] i12;
    logic [12:0] o;
    logic [4:0]  rs1, rs2, rd;
    int k, f;
    k   = $urandom_range(0, 9);
    i12 = 12'($urandom);
    rs1 = 5'($urandom_range(0, 31));
    rs2 = 5'($urandom_range(0, 31));
    rd  = 5'($urandom_range(0, 31));
    case (k)
      0, 1, 2: r = {i12, rs1, 3'b000, rd, 7'h13};
      3, 4, 5: begin
        f = $urandom_range(0, 4);
        case (f)
          0:       r = {7'h00, rs2, rs1, 3'b000, rd, 7'h33};
          1:       r = {7'h20, rs2, rs1, 3'b000, rd, 7'h33};
          2:       r = {7'h00, rs2, rs1, 3'b111, rd, 7'h33};
          3:       r = {7'h00, rs2, rs1, 3'b110, rd, 7'h33};
          default: r = {7'h00, rs2, rs1, 3'($urandom_range(1, 5)), rd, 7'h33};
        endcase
      end
      6: r = {i12, rs1, 3'b010, rd, 7'h03};
      7: r = {i12[11:5], rs2, rs1, 3'b010, i12[4:0], 7'h23};
      8: begin
        o   = 13'($urandom_range(0, 32) * 2) - 13'd32;
        rs1 = 5'($urandom_range(0, 3));
        rs2 = 5'($urandom_range(0, 3));
        r   = {o[12], o[10:5], rs2, rs1, 3'b000, o[4:1], o[11], 7'h63};
      end
      default: r = $urandom;
    endcase
    return r;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    model_step(1'b1);
    tick();
    model_step(1'b1);
    tick();
    checks++;
    if (dut.PC_current !== 32'd0)
      $display("FAIL reset_pc: got %h want %h", dut.PC_current, 32'd0);
    else passed++;
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (dut.register_file.regs[i] !== 32'd0)
        $display("FAIL reset_reg x%0d: got %h want %h", i, dut.register_file.regs[i], 32'd0);
      else passed++;
    end
    reset = 1'b0;
  endtask

  task automatic test_addi();
    logic [31:0] exp_v [4];
    exp_v = '{32'd5, 32'd10, 32'hFFFFFFF0, 32'd3};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dut.ALU_control !== 4'b0010)
        $display("FAIL addi_aluctl %0d: got %b want %b", i, dut.ALU_control, 4'b0010);
      else passed++;
      model_step(1'b0);
      tick();
      checks++;
      if (dut.register_file.regs[i + 1] !== exp_v[i])
        $display("FAIL addi_x%0d: got %h want %h", i + 1, dut.register_file.regs[i + 1], exp_v[i]);
      else passed++;
      checks++;
      if (dut.PC_current !== 32'(4 * (i + 1)))
        $display("FAIL addi_pc %0d: got %h want %h", i, dut.PC_current, 32'(4 * (i + 1)));
      else passed++;
    end
  endtask

  task automatic test_rtype();
    logic [31:0] exp_v [4];
    logic [3:0]  exp_c [4];
    exp_v = '{32'd15, 32'hFFFFFFFB, 32'd0, 32'd15};
    exp_c = '{4'b0010, 4'b0110, 4'b0000, 4'b0001};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dut.ALU_control !== exp_c[i])
        $display("FAIL rtype_aluctl %0d: got %b want %b", i, dut.ALU_control, exp_c[i]);
      else passed++;
      model_step(1'b0);
      tick();
      checks++;
      if (dut.register_file.regs[i + 5] !== exp_v[i])
        $display("FAIL rtype_x%0d: got %h want %h", i + 5, dut.register_file.regs[i + 5], exp_v[i]);
      else passed++;
    end
  endtask

  task automatic test_nop();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dut.RegWrite !== 1'b0)
        $display("FAIL nop_regwrite %0d: got %b want 0", i, dut.RegWrite);
      else passed++;
      model_step(1'b0);
      tick();
    end
    checks++;
    if (dut.PC_current !== 32'h34)
      $display("FAIL nop_pc: got %h want %h", dut.PC_current, 32'h34);
    else passed++;
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (dut.register_file.regs[i] !== m_regs[i])
        $display("FAIL nop_reg x%0d: got %h want %h", i, dut.register_file.regs[i], m_regs[i]);
      else passed++;
    end
    model_step(1'b0);
    tick();
    checks++;
    if (dut.register_file.regs[0] !== 32'd0)
      $display("FAIL x0_write: got %h want %h", dut.register_file.regs[0], 32'd0);
    else passed++;
  endtask

  task automatic test_mem();
    model_step(1'b0);
    tick();
    checks++;
    if (dut.dmem[2] !== 32'd10)
      $display("FAIL sw_dmem: got %h want %h", dut.dmem[2], 32'd10);
    else passed++;
    model_step(1'b0);
    tick();
    checks++;
    if (dut.register_file.regs[9] !== 32'd10)
      $display("FAIL lw_x9: got %h want %h", dut.register_file.regs[9], 32'd10);
    else passed++;
  endtask

  task automatic test_branch();
    checks++;
    if (dut.ALU_control !== 4'b0110)
      $display("FAIL beq_aluctl: got %b want %b", dut.ALU_control, 4'b0110);
    else passed++;
    model_step(1'b0);
    tick();
    checks++;
    if (dut.PC_current !== 32'h48)
      $display("FAIL beq_taken_pc: got %h want %h", dut.PC_current, 32'h48);
    else passed++;
    model_step(1'b0);
    tick();
    checks++;
    if (dut.PC_current !== 32'h4C)
      $display("FAIL beq_fall_pc: got %h want %h", dut.PC_current, 32'h4C);
    else passed++;
    model_step(1'b0);
    tick();
    checks++;
    if (dut.register_file.regs[11] !== 32'd2)
      $display("FAIL beq_x11: got %h want %h", dut.register_file.regs[11], 32'd2);
    else passed++;
    checks++;
    if (dut.register_file.regs[10] !== 32'd0)
      $display("FAIL beq_skip_x10: got %h want %h", dut.register_file.regs[10], 32'd0);
    else passed++;
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (dut.register_file.regs[i] !== m_regs[i])
        $display("FAIL directed_reg x%0d: got %h want %h", i, dut.register_file.regs[i], m_regs[i]);
      else passed++;
    end
  endtask

  task automatic run_random(input int cycles, input string tag);
    for (int c = 0; c < cycles; c++) begin
      model_step(1'b0);
      tick();
      checks++;
      if (dut.PC_current !== m_pc)
        $display("FAIL %s_pc cyc %0d: got %h want %h", tag, c, dut.PC_current, m_pc);
      else passed++;
      for (int i = 0; i < 32; i++) begin
        checks++;
        if (dut.register_file.regs[i] !== m_regs[i])
          $display("FAIL %s_reg cyc %0d x%0d: got %h want %h", tag, c, i,
                   dut.register_file.regs[i], m_regs[i]);
        else passed++;
      end
    end
  endtask

  task automatic test_random();
    reset = 1'b1;
    for (int i = 0; i < 256; i++) prog[i] = rand_instr();
    load_prog();
    model_step(1'b1);
    tick();
    reset = 1'b0;
    run_random(400, "rand");
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (dut.dmem[i] !== m_dmem[i])
        $display("FAIL rand_dmem %0d: got %h want %h", i, dut.dmem[i], m_dmem[i]);
      else passed++;
    end
  endtask

  task automatic test_mid_reset();
    run_random(25, "pre_rst");
    reset = 1'b1;
    model_step(1'b1);
    tick();
    reset = 1'b0;
    checks++;
    if (dut.PC_current !== 32'd0)
      $display("FAIL midrst_pc: got %h want %h", dut.PC_current, 32'd0);
    else passed++;
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (dut.register_file.regs[i] !== 32'd0)
        $display("FAIL midrst_reg x%0d: got %h want 0", i, dut.register_file.regs[i]);
      else passed++;
    end
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (dut.dmem[i] !== 32'd0)
        $display("FAIL midrst_dmem %0d: got %h want 0", i, dut.dmem[i]);
      else passed++;
    end
    run_random(30, "post_rst");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) prog[i] = 32'd0;
    prog[8'h00] = 32'h00500093;
    prog[8'h04] = 32'h00A00113;
    prog[8'h08] = 32'hFF000193;
    prog[8'h0C] = 32'h00300213;
    prog[8'h10] = 32'h002082B3;
    prog[8'h14] = 32'h40208333;
    prog[8'h18] = 32'h0020F3B3;
    prog[8'h1C] = 32'h0020E433;
    prog[8'h34] = 32'h00700013;
    prog[8'h38] = 32'h00202423;
    prog[8'h3C] = 32'h00802483;
    prog[8'h40] = 32'h00108463;
    prog[8'h44] = 32'h00100513;
    prog[8'h48] = 32'h00208463;
    prog[8'h4C] = 32'h00200593;
    load_prog();
    m_pc = 32'd0;

    test_reset();
    test_addi();
    test_rtype();
    test_nop();
    test_mem();
    test_branch();
    test_random();
    test_mid_reset();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
